// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-interface slice: bus widths,
// memory-interface FSM states and the timeout counter width.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam int TO_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } miu_state_t;

endpackage

// File: rtl/mem_iface_fsm.sv
// Handshake sequencer for the memory interface: IDLE -> ACCESS -> COMPLETE.
// Define MIU_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without an ack.
module mem_iface_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rm,
    input  logic wmem,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic mem_busy,
    output logic mem_done,
    output logic mem_err,
    output logic load_en,
    output logic rd_capture
);

    miu_state_t state_q, state_d;
    logic       we_q;
    logic       accept;
    logic       timeout_hit;

`ifdef MIU_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q;
    logic                err_q;

    assign timeout_hit = (cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));
    assign mem_err     = err_q;

    // An ack on the limit cycle wins, so the error only sets on a bare timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
            if (!mem_ack && timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q <= wmem;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load_en    = 1'b0;
        accept     = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            IDLE, COMPLETE: begin
                load_en = 1'b1;
                if (rm || wmem) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    rd_capture = !we_q;
                    state_d    = COMPLETE;
                end else if (timeout_hit) begin
                    state_d = COMPLETE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req  = (state_q == ACCESS);
    assign mem_busy = (state_q == ACCESS);
    assign mem_done = (state_q == COMPLETE);
    assign mem_we   = we_q;

endmodule

// File: rtl/mem_iface_unit.sv
// Memory interface stage: owns MAR/MDR, drives the req/ack handshake and
// reports busy/done to the sequencer. Optional timeout via MIU_TIMEOUT_EN.
module mem_iface_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              wmar,
    input  logic              wmdr,
    input  logic              rmdr,
    input  logic              rm,
    input  logic              wmem,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              load_en;
    logic              rd_capture;

    mem_iface_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rm         (rm),
        .wmem       (wmem),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_err    (mem_err),
        .load_en    (load_en),
        .rd_capture (rd_capture)
    );

    // Loads share the accepting edge, so a new transaction sees fresh MAR/MDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (load_en && wmar) begin
                mar <= bus_in[ADDR_W-1:0];
            end
            if (rd_capture) begin
                mdr <= mem_rdata;
            end else if (load_en && wmdr) begin
                mdr <= bus_in;
            end
        end
    end

    assign bus_out   = rmdr ? mdr : '0;
    assign bus_oe    = rmdr;
    assign mar_q     = mar;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_iface_unit.sv
// Self-checking bench for mem_iface_unit: transaction-level model plus
// directed scenarios. Define MIU_TIMEOUT_EN to exercise the timeout path.
module tb_mem_iface_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int TO_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] bus_in;
    logic              wmar, wmdr, rmdr, rm, wmem;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [ADDR_W-1:0] mar_q;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy, mem_done, mem_err;

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;

    mem_iface_unit #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .wmar      (wmar),
        .wmdr      (wmdr),
        .rmdr      (rmdr),
        .rm        (rm),
        .wmem      (wmem),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .mar_q     (mar_q),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

`ifdef MIU_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic a_wmar, input logic a_wmdr,
                                 input logic a_rmdr, input logic a_rm, input logic a_wmem,
                                 input logic a_ack, input logic [31:0] rdata);
        bus_in    = b;
        wmar      = a_wmar;
        wmdr      = a_wmdr;
        rmdr      = a_rmdr;
        rm        = a_rm;
        wmem      = a_wmem;
        mem_ack   = a_ack;
        mem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one in-flight flag, a done pulse, sticky error.
    logic              m_inflight, m_we, m_done, m_err;
    logic [ADDR_W-1:0] m_mar;
    logic [DATA_W-1:0] m_mdr;
    int                m_cycles;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight = 1'b0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_mar = '0; m_mdr = '0; m_cycles = 0;
        end else begin
            m_done = 1'b0;
            if (m_inflight) begin
                m_cycles++;
                if (mem_ack) begin
                    if (!m_we) m_mdr = mem_rdata;
                    m_inflight = 1'b0;
                    m_done     = 1'b1;
                end else if (TIMEOUT_ON && m_cycles == TO_CYC) begin
                    m_inflight = 1'b0;
                    m_done     = 1'b1;
                    m_err      = 1'b1;
                end
            end else begin
                if (wmar) m_mar = bus_in[ADDR_W-1:0];
                if (wmdr) m_mdr = bus_in;
                if (rm || wmem) begin
                    m_inflight = 1'b1;
                    m_we       = wmem;
                    m_cycles   = 0;
                    m_err      = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, m_inflight});
        checkOutput("mem_busy", {31'b0, mem_busy}, {31'b0, m_inflight});
        checkOutput("mem_done", {31'b0, mem_done}, {31'b0, m_done});
        checkOutput("mem_err", {31'b0, mem_err}, {31'b0, m_err});
        checkOutput("mar_q", {16'b0, mar_q}, {16'b0, m_mar});
        checkOutput("mem_addr", {16'b0, mem_addr}, {16'b0, m_mar});
        checkOutput("mem_wdata", mem_wdata, m_mdr);
        checkOutput("bus_out", bus_out, rmdr ? m_mdr : 32'h0);
        checkOutput("bus_oe", {31'b0, bus_oe}, {31'b0, rmdr});
        if (m_inflight) checkOutput("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        if (mem_done) done_count++;
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        bus_in = '0; wmar = 0; wmdr = 0; rmdr = 0; rm = 0; wmem = 0;
        mem_ack = 0; mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_mar", {16'b0, mar_q}, 32'h0);
        checkOutput("rst_bus_out", bus_out, 32'h0);
        rst_n = 1'b1;

        $display("[TB] reset during ACCESS");
        applyStimulus(32'h0055, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h000000AA, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("pre_rst_req", {31'b0, mem_req}, 32'h1);
        checkOutput("pre_rst_mar", {16'b0, mar_q}, 32'h0055);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", {31'b0, mem_req}, 32'h0);
        checkOutput("async_rst_busy", {31'b0, mem_busy}, 32'h0);
        checkOutput("async_rst_mar", {16'b0, mar_q}, 32'h0);
        checkOutput("async_rst_mdr", mem_wdata, 32'h0);
        base = done_count;
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_no_done", done_count, base);

        $display("[TB] write with ack on third ACCESS cycle");
        applyStimulus(32'h0010, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0);
        base = done_count;
        applyStimulus(32'h0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("wr_addr", {16'b0, mem_addr}, 32'h0010);
        checkOutput("wr_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("wr_we", {31'b0, mem_we}, 32'h1);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_busy_c3", {31'b0, mem_busy}, 32'h1);
        checkOutput("wr_we_c3", {31'b0, mem_we}, 32'h1);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'h0);
        checkOutput("wr_done", {31'b0, mem_done}, 32'h1);
        checkOutput("wr_req_drop", {31'b0, mem_req}, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_one_done", done_count, base + 1);

        $display("[TB] read with ack on first ACCESS cycle");
        applyStimulus(32'h0020, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        rmdr = 1'b1;
        #1;
        checkOutput("rd_pre_bus", bus_out, 32'hDEADBEEF);
        checkOutput("rd_we", {31'b0, mem_we}, 32'h0);
        applyStimulus(32'h0, 0, 0, 1, 0, 0, 1, 32'h12345678);
        checkOutput("rd_bus_out", bus_out, 32'h12345678);
        checkOutput("rd_bus_oe", {31'b0, bus_oe}, 32'h1);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_bus_idle", bus_out, 32'h0);

        $display("[TB] rm+wmem together, loads ignored in ACCESS, back-to-back");
        base = done_count;
        applyStimulus(32'h0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("both_we", {31'b0, mem_we}, 32'h1);
        applyStimulus(32'hBEEF, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("frozen_mar", {16'b0, mar_q}, 32'h0020);
        checkOutput("frozen_mdr", mem_wdata, 32'h12345678);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
        checkOutput("wr_keeps_mdr", mem_wdata, 32'h12345678);
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("b2b_req", {31'b0, mem_req}, 32'h1);
        checkOutput("b2b_we", {31'b0, mem_we}, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_two_done", done_count, base + 2);
        checkOutput("b2b_mdr", mem_wdata, 32'hCAFEF00D);

        $display("[TB] stray ack in IDLE");
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'h11111111);
        checkOutput("stray_mdr", mem_wdata, 32'hCAFEF00D);
        checkOutput("stray_done", {31'b0, mem_done}, 32'h0);

`ifdef MIU_TIMEOUT_EN
        $display("[TB] timeout without ack");
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        n = 0;
        while (n < 10 && !mem_done) begin
            applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("to_cycles", n, TO_CYC);
        checkOutput("to_err", {31'b0, mem_err}, 32'h1);
        checkOutput("to_mdr", mem_wdata, 32'hCAFEF00D);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("to_err_sticky", {31'b0, mem_err}, 32'h1);
        checkOutput("to_done_once", {31'b0, mem_done}, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("to_err_clear", {31'b0, mem_err}, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        checkOutput("to_next_ok", mem_wdata, 32'h0BADF00D);
`else
        $display("[TB] ACCESS waits without ack");
        applyStimulus(32'h0, 0, 0, 0, 1, 0, 0, 0);
        n = 0;
        repeat (12) begin
            applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checkOutput("wait_busy", {31'b0, mem_busy}, 32'h1);
        checkOutput("wait_err", {31'b0, mem_err}, 32'h0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        checkOutput("wait_done", {31'b0, mem_done}, 32'h1);
        checkOutput("wait_mdr", mem_wdata, 32'h0BADF00D);
`endif
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(32'h0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
